// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants (active-low, bit 0 = segment a) shared by the adder display.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_HA    = 7'h08;
  localparam logic [SEG_W-1:0] SEG_HB    = 7'h03;
  localparam logic [SEG_W-1:0] SEG_HC    = 7'h46;
  localparam logic [SEG_W-1:0] SEG_HD    = 7'h21;
  localparam logic [SEG_W-1:0] SEG_HE    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HF    = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // True when the given segment is lit in an active-low glyph.
  function automatic logic seg_lit(input logic [SEG_W-1:0] glyph, input int idx);
    return ~glyph[idx];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit to active-low seven-segment hex decoder (glyphs 0-9, A, b, C, d, E, F).
// Zero latency, no handshake.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       value,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_HA;
      4'hB: seg = SEG_HB;
      4'hC: seg = SEG_HC;
      4'hD: seg = SEG_HD;
      4'hE: seg = SEG_HE;
      4'hF: seg = SEG_HF;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/top_adder_display.sv
// 4-bit adder (A + B + cin) shown as one hex digit, carry-out on Overflow.
// Outputs registered: 1-cycle latency, no handshake; outputs hold while inputs are static.
module top_adder_display
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic             cin,
  output logic [SEG_W-1:0] D,
  output logic             Overflow
);

  logic [4:0]       sum;
  logic [SEG_W-1:0] glyph;

  // Widen before adding so the carry survives into sum[4].
  assign sum = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

  hex_to_7seg u_dec (
    .value (sum[3:0]),
    .seg   (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      D        <= SEG_BLANK;
      Overflow <= 1'b0;
    end else begin
      D        <= glyph;
      Overflow <= sum[4];
    end
  end

endmodule

// File: tb/tb_top_adder_display.sv
// Self-checking bench for top_adder_display against an arithmetic reference model.
module tb_top_adder_display;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [6:0] d;
  logic       ovf;

  int total;
  int bad;

  // Independent glyph table, indexed by digit value.
  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  top_adder_display dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .cin      (cin),
    .D        (d),
    .Overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int x, input int y, input int c);
    int s;
    logic [6:0] g;
    s = (x + y + c) % 16;
    g = glyph_tab[s];
    return g;
  endfunction

  function automatic logic exp_ovf(input int x, input int y, input int c);
    return (x + y + c) > 15;
  endfunction

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive_and_clock(input logic r, input logic [3:0] x, input logic [3:0] y, input logic c);
    @(negedge clk);
    rst = r; a = x; b = y; cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_and_clock(1'b1, 4'h9, 4'h3, 1'b1);
    total++;
    if (d !== 7'h7F) begin bad++; $display("FAIL reset_d got=%h exp=%h", d, 7'h7F); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_basic();
    drive_and_clock(1'b0, 4'h2, 4'h2, 1'b0);
    total++;
    if (d !== 7'h19 || ovf !== 1'b0) begin
      bad++; $display("FAIL basic_2p2 got d=%h ovf=%b exp d=19 ovf=0", d, ovf);
    end
    drive_and_clock(1'b0, 4'h0, 4'h1, 1'b0);
    total++;
    if (d !== 7'h79 || ovf !== 1'b0) begin
      bad++; $display("FAIL basic_0p1 got d=%h ovf=%b exp d=79 ovf=0", d, ovf);
    end
  endtask

  task automatic test_carry_in();
    drive_and_clock(1'b0, 4'h7, 4'h7, 1'b1);
    total++;
    if (d !== 7'h0E || ovf !== 1'b0) begin
      bad++; $display("FAIL carry_in got d=%h ovf=%b exp d=0e ovf=0", d, ovf);
    end
  endtask

  task automatic test_overflow();
    drive_and_clock(1'b0, 4'hF, 4'h1, 1'b0);
    total++;
    if (d !== 7'h40 || ovf !== 1'b1) begin
      bad++; $display("FAIL wrap_f1 got d=%h ovf=%b exp d=40 ovf=1", d, ovf);
    end
    drive_and_clock(1'b0, 4'hF, 4'hF, 1'b1);
    total++;
    if (d !== 7'h0E || ovf !== 1'b1) begin
      bad++; $display("FAIL wrap_ffc got d=%h ovf=%b exp d=0e ovf=1", d, ovf);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      drive_and_clock(1'b0, 4'(i), 4'h0, 1'b0);
      total++;
      if (d !== exp_seg(i, 0, 0) || ovf !== 1'b0) begin
        bad++; $display("FAIL sweep_%0d got d=%h ovf=%b exp d=%h ovf=0", i, d, ovf, exp_seg(i, 0, 0));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int x, y, c;
      x = int'($urandom_range(15, 0));
      y = int'($urandom_range(15, 0));
      c = int'($urandom_range(1, 0));
      drive_and_clock(1'b0, 4'(x), 4'(y), 1'(c));
      total++;
      if (d !== exp_seg(x, y, c) || ovf !== exp_ovf(x, y, c)) begin
        bad++;
        $display("FAIL random_%0d a=%0d b=%0d cin=%0d got d=%h ovf=%b exp d=%h ovf=%b",
                 n, x, y, c, d, ovf, exp_seg(x, y, c), exp_ovf(x, y, c));
      end
    end
  endtask

  task automatic test_latency();
    drive_and_clock(1'b0, 4'h3, 4'h5, 1'b0);
    @(negedge clk);
    a = 4'hC; b = 4'h6; cin = 1'b1;
    #1;
    total++;
    if (d !== exp_seg(3, 5, 0) || ovf !== 1'b0) begin
      bad++; $display("FAIL latency_hold got d=%h ovf=%b exp d=%h ovf=0", d, ovf, exp_seg(3, 5, 0));
    end
    @(posedge clk);
    #1;
    total++;
    if (d !== exp_seg(12, 6, 1) || ovf !== 1'b1) begin
      bad++; $display("FAIL latency_update got d=%h ovf=%b exp d=%h ovf=1", d, ovf, exp_seg(12, 6, 1));
    end
  endtask

  task automatic test_reset_priority();
    drive_and_clock(1'b0, 4'h8, 4'h9, 1'b0);
    drive_and_clock(1'b1, 4'h1, 4'h2, 1'b0);
    total++;
    if (d !== 7'h7F || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_priority got d=%h ovf=%b exp d=7f ovf=0", d, ovf);
    end
    drive_and_clock(1'b1, 4'h1, 4'h2, 1'b0);
    total++;
    if (d !== 7'h7F || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_hold got d=%h ovf=%b exp d=7f ovf=0", d, ovf);
    end
    drive_and_clock(1'b0, 4'h1, 4'h2, 1'b0);
    total++;
    if (d !== 7'h30 || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_release got d=%h ovf=%b exp d=30 ovf=0", d, ovf);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; a = 4'h0; b = 4'h0; cin = 1'b0;
    test_reset();
    test_basic();
    test_carry_in();
    test_overflow();
    test_sweep();
    test_random();
    test_latency();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
